// File: rtl/alu_issue_ctrl_pkg.sv
// Shared widths, ALU opcode names and sequencer state encoding for alu_issue_ctrl.
package alu_issue_ctrl_pkg;

  localparam int DATA_SIZE  = 32;
  localparam int ADDR_SIZE  = 6;
  localparam int ALUOP_SIZE = 4;

  // ALU opcode used by the add path of the existing ALU.
  localparam logic [ALUOP_SIZE-1:0] ALU_OP_ADD = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_OPLD = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_e;

  // Result is committed unless the ALU overflowed and overflow write-back is disabled.
  function automatic logic wb_allowed(input logic ovf, input logic wb_on_ovf);
    return (~ovf) | wb_on_ovf;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_fsm.sv
// Next-state logic of the single-instruction ALU sequencer.
module alu_issue_ctrl_fsm
  import alu_issue_ctrl_pkg::*;
(
  input  state_e i_state,
  input  logic   i_accept,
  output state_e o_next_state
);

  // One instruction walks IDLE -> READ -> OPLD -> EXEC -> WB -> IDLE.
  always_comb begin
    o_next_state = ST_IDLE;
    case (i_state)
      ST_IDLE: begin
        if (i_accept) begin
          o_next_state = ST_READ;
        end else begin
          o_next_state = ST_IDLE;
        end
      end
      ST_READ: o_next_state = ST_OPLD;
      ST_OPLD: o_next_state = ST_EXEC;
      ST_EXEC: o_next_state = ST_WB;
      ST_WB:   o_next_state = ST_IDLE;
      default: o_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU instruction at a time: register read, operand load, execute, write-back.
// All outputs are registered; per-state strobes are computed from the next state.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter bit WB_ON_OVF = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_instr_valid,
  output logic                  o_instr_ready,
  input  logic [ALUOP_SIZE-1:0] i_instr_op,
  input  logic [ADDR_SIZE-1:0]  i_instr_rs1,
  input  logic [ADDR_SIZE-1:0]  i_instr_rs2,
  input  logic [ADDR_SIZE-1:0]  i_instr_rd,
  output logic [ADDR_SIZE-1:0]  o_rf_read_addr1,
  output logic [ADDR_SIZE-1:0]  o_rf_read_addr2,
  input  logic [DATA_SIZE-1:0]  i_rf_read_data1,
  input  logic [DATA_SIZE-1:0]  i_rf_read_data2,
  output logic                  o_rf_write,
  output logic [ADDR_SIZE-1:0]  o_rf_write_addr,
  output logic [DATA_SIZE-1:0]  o_rf_write_data,
  output logic                  o_alu_enable,
  output logic [ALUOP_SIZE-1:0] o_alu_op,
  output logic [DATA_SIZE-1:0]  o_alu_src1,
  output logic [DATA_SIZE-1:0]  o_alu_src2,
  input  logic [DATA_SIZE-1:0]  i_alu_out,
  input  logic                  i_alu_overflow,
  output logic                  o_done,
  output logic                  o_busy,
  input  logic                  i_ovf_clear,
  output logic                  o_ovf_flag,
  output logic [CNT_WIDTH-1:0]  o_instr_cnt
);

  state_e                r_state;
  state_e                w_next_state;
  logic                  w_accept;

  logic                  r_ready;
  logic                  r_busy;
  logic                  r_alu_enable;
  logic                  r_done;
  logic                  r_rf_write;
  logic [ALUOP_SIZE-1:0] r_op;
  logic [ADDR_SIZE-1:0]  r_rd;
  logic [ADDR_SIZE-1:0]  r_read_addr1;
  logic [ADDR_SIZE-1:0]  r_read_addr2;
  logic [DATA_SIZE-1:0]  r_src1;
  logic [DATA_SIZE-1:0]  r_src2;
  logic [ALUOP_SIZE-1:0] r_alu_op;
  logic [DATA_SIZE-1:0]  r_result;
  logic [ADDR_SIZE-1:0]  r_wr_addr;
  logic                  r_ovf_q;
  logic                  r_ovf_flag;
  logic [CNT_WIDTH-1:0]  r_cnt;

  assign w_accept = i_instr_valid & r_ready;

  alu_issue_ctrl_fsm u_fsm (
    .i_state      (r_state),
    .i_accept     (w_accept),
    .o_next_state (w_next_state)
  );

  // State register plus strobes registered one cycle ahead so they line up with their state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_alu_enable <= 1'b0;
      r_done       <= 1'b0;
      r_rf_write   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_ready      <= (w_next_state == ST_IDLE);
      r_busy       <= (w_next_state != ST_IDLE);
      r_alu_enable <= (w_next_state == ST_EXEC);
      r_done       <= (w_next_state == ST_WB);
      // Only EXEC leads to WB, so the live ALU overflow is the one being captured into r_ovf_q.
      r_rf_write   <= (w_next_state == ST_WB) & wb_allowed(i_alu_overflow, WB_ON_OVF);
    end
  end

  // Instruction latch, operand load and execute capture; values hold outside their step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op         <= {ALUOP_SIZE{1'b0}};
      r_rd         <= {ADDR_SIZE{1'b0}};
      r_read_addr1 <= {ADDR_SIZE{1'b0}};
      r_read_addr2 <= {ADDR_SIZE{1'b0}};
      r_src1       <= {DATA_SIZE{1'b0}};
      r_src2       <= {DATA_SIZE{1'b0}};
      r_alu_op     <= {ALUOP_SIZE{1'b0}};
      r_result     <= {DATA_SIZE{1'b0}};
      r_wr_addr    <= {ADDR_SIZE{1'b0}};
      r_ovf_q      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op         <= i_instr_op;
        r_rd         <= i_instr_rd;
        r_read_addr1 <= i_instr_rs1;
        r_read_addr2 <= i_instr_rs2;
      end
      if (r_state == ST_OPLD) begin
        r_src1   <= i_rf_read_data1;
        r_src2   <= i_rf_read_data2;
        r_alu_op <= r_op;
      end
      if (r_state == ST_EXEC) begin
        r_result  <= i_alu_out;
        r_ovf_q   <= i_alu_overflow;
        r_wr_addr <= r_rd;
      end
    end
  end

  // Sticky overflow (set beats clear) and wrapping retired-instruction counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf_flag <= 1'b0;
      r_cnt      <= {CNT_WIDTH{1'b0}};
    end else begin
      if ((r_state == ST_WB) && r_ovf_q) begin
        r_ovf_flag <= 1'b1;
      end else if (i_ovf_clear) begin
        r_ovf_flag <= 1'b0;
      end
      if (r_state == ST_WB) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign o_instr_ready   = r_ready;
  assign o_busy          = r_busy;
  assign o_rf_read_addr1 = r_read_addr1;
  assign o_rf_read_addr2 = r_read_addr2;
  assign o_rf_write      = r_rf_write;
  assign o_rf_write_addr = r_wr_addr;
  assign o_rf_write_data = r_result;
  assign o_alu_enable    = r_alu_enable;
  assign o_alu_op        = r_alu_op;
  assign o_alu_src1      = r_src1;
  assign o_alu_src2      = r_src2;
  assign o_done          = r_done;
  assign o_ovf_flag      = r_ovf_flag;
  assign o_instr_cnt     = r_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: register file and adding ALU stub, a queue-based
// reference model fed at issue time, and an independent monitor that checks each retire.
module tb_alu_issue_ctrl;

  localparam int CW = 2;
  localparam bit WB_OVF = 1'b0;

  typedef struct {
    int          t;
    logic [3:0]  op;
    logic [5:0]  rd;
    logic [31:0] data;
    bit          wr;
    bit          flag;
    int          cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_instr_valid = 1'b0;
  logic [3:0]    i_instr_op = 4'd0;
  logic [5:0]    i_instr_rs1 = 6'd0, i_instr_rs2 = 6'd0, i_instr_rd = 6'd0;
  logic          i_ovf_clear = 1'b0;
  logic          o_instr_ready, o_rf_write, o_alu_enable, o_done, o_busy, o_ovf_flag;
  logic [5:0]    o_rf_read_addr1, o_rf_read_addr2, o_rf_write_addr;
  logic [31:0]   rd1, rd2, o_rf_write_data, o_alu_src1, o_alu_src2, alu_out;
  logic          alu_ovf;
  logic [3:0]    o_alu_op;
  logic [CW-1:0] o_instr_cnt;

  logic [31:0]   rf  [64];
  logic [31:0]   mdl [64];
  logic          pre_we = 1'b0;
  logic [5:0]    pre_addr = 6'd0;
  logic [31:0]   pre_data = 32'd0;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   mflag = 1'b0;
  int   mcnt = 0;

  alu_issue_ctrl #(.WB_ON_OVF(WB_OVF), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
    .i_instr_op(i_instr_op), .i_instr_rs1(i_instr_rs1), .i_instr_rs2(i_instr_rs2),
    .i_instr_rd(i_instr_rd), .o_rf_read_addr1(o_rf_read_addr1), .o_rf_read_addr2(o_rf_read_addr2),
    .i_rf_read_data1(rd1), .i_rf_read_data2(rd2), .o_rf_write(o_rf_write),
    .o_rf_write_addr(o_rf_write_addr), .o_rf_write_data(o_rf_write_data),
    .o_alu_enable(o_alu_enable), .o_alu_op(o_alu_op), .o_alu_src1(o_alu_src1),
    .o_alu_src2(o_alu_src2), .i_alu_out(alu_out), .i_alu_overflow(alu_ovf), .o_done(o_done),
    .o_busy(o_busy), .i_ovf_clear(i_ovf_clear), .o_ovf_flag(o_ovf_flag), .o_instr_cnt(o_instr_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ALU stub: plain add with signed-add overflow.
  assign alu_out = o_alu_src1 + o_alu_src2;
  assign alu_ovf = (o_alu_src1[31] == o_alu_src2[31]) && (alu_out[31] != o_alu_src1[31]);

  // Register file with synchronous read and a bench preload port.
  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (o_rf_write) rf[o_rf_write_addr] <= o_rf_write_data;
    rd1 <= rf[o_rf_read_addr1];
    rd2 <= rf[o_rf_read_addr2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},  32'(o_instr_ready), 32'd1);
    check({tag, "_busy"},   32'(o_busy), 32'd0);
    check({tag, "_done"},   32'(o_done), 32'd0);
    check({tag, "_rfw"},    32'(o_rf_write), 32'd0);
    check({tag, "_aluen"},  32'(o_alu_enable), 32'd0);
    check({tag, "_aluop"},  32'(o_alu_op), 32'd0);
    check({tag, "_src1"},   o_alu_src1, 32'd0);
    check({tag, "_src2"},   o_alu_src2, 32'd0);
    check({tag, "_ra1"},    32'(o_rf_read_addr1), 32'd0);
    check({tag, "_ra2"},    32'(o_rf_read_addr2), 32'd0);
    check({tag, "_wa"},     32'(o_rf_write_addr), 32'd0);
    check({tag, "_wd"},     o_rf_write_data, 32'd0);
    check({tag, "_ovf"},    32'(o_ovf_flag), 32'd0);
    check({tag, "_cnt"},    32'(o_instr_cnt), 32'd0);
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic idle_clear();
    i_ovf_clear = 1'b1;
    @(negedge clk);
    i_ovf_clear = 1'b0;
    mflag = 1'b0;
    check("ovf_clear_idle", 32'(o_ovf_flag), 32'd0);
  endtask

  // Offer one instruction (called at a falling edge) and follow it until ready returns.
  task automatic issue(input logic [3:0] op, input logic [5:0] rs1, input logic [5:0] rs2,
                       input logic [5:0] rd, input bit keep, input bit clr_wb, input bit b2b);
    exp_t e;
    int n;
    logic [31:0] a, b, s;
    bit ov;
    i_instr_op = op; i_instr_rs1 = rs1; i_instr_rs2 = rs2; i_instr_rd = rd;
    i_instr_valid = 1'b1;
    n = 0;
    while (!o_instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_instr_ready) begin
      check("accept_timeout", 32'(o_instr_ready), 32'd1);
      i_instr_valid = 1'b0;
      return;
    end
    a = mdl[rs1]; b = mdl[rs2]; s = a + b;
    ov = (a[31] == b[31]) && (s[31] != a[31]);
    e.t = cyc; e.op = op; e.rd = rd; e.data = s;
    e.wr = WB_OVF || !ov;
    if (e.wr) mdl[rd] = s;
    if (ov) mflag = 1'b1;
    else if (clr_wb) mflag = 1'b0;
    e.flag = mflag;
    mcnt = (mcnt + 1) % (1 << CW);
    e.cnt = mcnt;
    if (b2b) check("b2b_gap", 32'(cyc - last_acc), 32'd5);
    last_acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) i_instr_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("ready_busy", 32'(o_instr_ready), 32'd0);
      check("busy_high", 32'(o_busy), 32'd1);
      if (k == 4 && clr_wb) i_ovf_clear = 1'b1;
    end
    @(negedge clk);
    i_ovf_clear = 1'b0;
    check("ready_back", 32'(o_instr_ready), 32'd1);
    check("busy_low", 32'(o_busy), 32'd0);
  endtask

  // Monitor: pops the expectation on every retire and checks the following cycle's status.
  initial begin : monitor
    exp_t pe;
    bit   pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("ovf_flag", 32'(o_ovf_flag), 32'(pe.flag));
        check("instr_cnt", 32'(o_instr_cnt), 32'(pe.cnt));
        pend = 1'b0;
      end
      if (rst) continue;
      if (o_alu_enable) begin
        if (exp_q.size() == 0) check("alu_en_unexpected", 32'd1, 32'd0);
        else check("alu_op", 32'(o_alu_op), 32'(exp_q[0].op));
      end
      if (o_done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          pe = exp_q.pop_front();
          check("latency", 32'(cyc - pe.t), 32'd4);
          check("rf_write", 32'(o_rf_write), 32'(pe.wr));
          if (pe.wr) begin
            check("wr_addr", 32'(o_rf_write_addr), 32'(pe.rd));
            check("wr_data", o_rf_write_data, pe.data);
          end
          pend = 1'b1;
        end
      end else if (o_rf_write) begin
        check("rf_write_stray", 32'd1, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] keep4;
    bit prev_keep, kp;
    int n;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) preload(6'(i), $urandom);

    // Basic add.
    preload(6'd1, 32'h0F0F0F0F);
    preload(6'd2, 32'h00000001);
    issue(4'b1000, 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b0);
    check("add_r3", rf[3], 32'h0F0F0F10);

    // Overflow suppresses write-back; set beats a simultaneous clear.
    preload(6'd1, 32'h7FFFFFFF);
    preload(6'd4, 32'h12345678);
    keep4 = rf[4];
    issue(4'b1000, 6'd1, 6'd2, 6'd4, 1'b0, 1'b0, 1'b0);
    check("ovf_r4_kept", rf[4], keep4);
    check("ovf_set", 32'(o_ovf_flag), 32'd1);
    issue(4'b1000, 6'd1, 6'd2, 6'd7, 1'b0, 1'b1, 1'b0);
    check("ovf_set_wins", 32'(o_ovf_flag), 32'd1);
    idle_clear();

    // Back-to-back with valid held high.
    issue(4'b0011, 6'd8, 6'd9, 6'd10, 1'b1, 1'b0, 1'b0);
    issue(4'b0101, 6'd10, 6'd11, 6'd12, 1'b0, 1'b0, 1'b1);

    // Reset while in OPLD abandons the instruction.
    i_instr_op = 4'b1000; i_instr_rs1 = 6'd2; i_instr_rs2 = 6'd2; i_instr_rd = 6'd13;
    i_instr_valid = 1'b1;
    @(posedge clk);
    #1;
    i_instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    mcnt = 0;
    mflag = 1'b0;
    repeat (3) @(negedge clk);

    // Destination equals source, then counter wrap after four retires.
    preload(6'd5, 32'hFFFF0000);
    preload(6'd6, 32'h0000FFFF);
    issue(4'b1000, 6'd5, 6'd6, 6'd5, 1'b0, 1'b0, 1'b0);
    check("self_r5", rf[5], 32'hFFFFFFFF);
    issue(4'b0001, 6'd20, 6'd21, 6'd22, 1'b0, 1'b0, 1'b0);
    issue(4'b0010, 6'd23, 6'd24, 6'd25, 1'b0, 1'b0, 1'b0);
    issue(4'b0100, 6'd26, 6'd27, 6'd28, 1'b0, 1'b0, 1'b0);
    check("cnt_wrap", 32'(o_instr_cnt), 32'd0);

    // Randomized traffic.
    prev_keep = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!prev_keep && ($urandom_range(0, 4) == 0)) idle_clear();
      if (!prev_keep && ($urandom_range(0, 4) == 0)) preload(6'($urandom), $urandom);
      kp = (i != 39) && ($urandom_range(0, 2) == 0);
      issue(4'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), kp,
            ($urandom_range(0, 3) == 0), prev_keep);
      prev_keep = kp;
    end

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 64; i++) check("rf_final", rf[i], mdl[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencer that accepts one ALU instruction at a time over a valid/ready handshake.
- Runs each instruction through four steps: reads both source operands from the 64x32 register file, drives the combinational ALU, and writes the result back to the register file.
- Sits between the instruction source (decoder or testbench) and the ALU/register-file pair, and owns the ALU's alu_enable and alu_op.
- Keeps a sticky overflow status and a retired-instruction counter.

Parameters:
DATA_SIZE, 32, operand/result width
ADDR_SIZE, 6, register-file address width (64 entries)
ALUOP_SIZE, 4, ALU opcode width
WB_ON_OVF, 1, 1 = write back even when ALU overflows; 0 = suppress write on overflow
CNT_WIDTH, 16, retired-instruction counter width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  controller can accept (IDLE only)
instr_op  input  ALUOP_SIZE  ALU opcode
instr_rs1  input  ADDR_SIZE  source-1 register
instr_rs2  input  ADDR_SIZE  source-2 register
instr_rd  input  ADDR_SIZE  destination register
rf_read_addr1  output  ADDR_SIZE  register-file read port 1 address
rf_read_addr2  output  ADDR_SIZE  register-file read port 2 address
rf_read_data1  input  DATA_SIZE  read data 1, valid one cycle after address
rf_read_data2  input  DATA_SIZE  read data 2, valid one cycle after address
rf_write  output  1  register-file write strobe
rf_write_addr  output  ADDR_SIZE  write address
rf_write_data  output  DATA_SIZE  write data
alu_enable  output  1  ALU enable
alu_op  output  ALUOP_SIZE  ALU opcode
alu_src1  output  DATA_SIZE  ALU operand 1
alu_src2  output  DATA_SIZE  ALU operand 2
alu_out  input  DATA_SIZE  ALU result (combinational)
alu_overflow  input  1  ALU overflow (combinational)
done  output  1  one-cycle pulse when an instruction retires
busy  output  1  high in any state other than IDLE
ovf_clear  input  1  clears ovf_flag
ovf_flag  output  1  sticky overflow status
instr_cnt  output  CNT_WIDTH  retired-instruction count, wraps

Behaviour:
- FSM states: IDLE, READ, OPLD, EXEC, WB. Exactly one instruction in flight; no pipelining, so no hazards.
- IDLE: instr_ready=1. When instr_valid & instr_ready, latch op/rs1/rs2/rd, then go to READ.
- READ: rf_read_addr1/2 = latched rs1/rs2. Next state OPLD.
- OPLD: capture rf_read_data1/2 into operand registers src1_q/src2_q. Next state EXEC.
- EXEC: alu_enable=1, alu_op = latched op. alu_src1/2 are driven from src1_q/src2_q, which are registered outputs held in all states.
  - Capture alu_out into result_q and alu_overflow into ovf_q.
  - Next state WB.
- WB:
  - rf_write = 1 unless (ovf_q & WB_ON_OVF==0).
  - rf_write_addr = latched rd; rf_write_data = result_q.
  - done=1 and instr_cnt increments, regardless of suppression.
  - Next state IDLE.
- Latency and throughput:
  - Handshake in cycle T; rf_write/done in cycle T+4.
  - Next accept is possible at T+5, so peak throughput is 1 instruction per 5 cycles.
- Outputs outside their active state: rf_write=0, done=0, alu_enable=0. Addresses and data hold their last values.
- ovf_flag:
  - Set in WB when ovf_q=1.
  - Cleared by ovf_clear.
  - Set and clear in the same cycle: set wins.
- instr_cnt wraps from all-ones to 0 with no flag.
- rd equal to rs1 or rs2 is legal: the read completes before the write.
- Reset values: state=IDLE, instr_ready=1 (IDLE), busy=0, done=0, rf_write=0, alu_enable=0, alu_op=0, alu_src1/2=0, read/write addrs=0, rf_write_data=0, ovf_flag=0, instr_cnt=0.
- Reset mid-operation: the instruction is abandoned, no rf_write occurs, no done pulse, and the counter is zeroed.
- instr_valid while busy: ignored. The source must hold it until ready.

Decomposition:
- Shared package/header: DATA_SIZE, ADDR_SIZE, ALUOP_SIZE, and the state encodings (IDLE=0 through WB=4, 3-bit). The existing ALU opcode defines are reused unchanged.
- Sub-module: none required. An optional alu_issue_fsm holding only the next-state logic is acceptable.

Test Plan:
- Bench ALU stub: out = src1+src2, overflow = signed-add overflow.
- Basic add: R1=0x0F0F0F0F, R2=0x00000001; issue rs1=1, rs2=2, rd=3, op=4'b1000 -> rf_write at T+4, R3=0x0F0F0F10, done pulse, instr_cnt=1, ovf_flag=0.
- Overflow with WB_ON_OVF=0: R1=0x7FFFFFFF, R2=0x00000001, rd=4 -> no rf_write, R4 unchanged, done=1, ovf_flag=1. Then ovf_clear together with a second overflowing instruction's WB -> ovf_flag stays 1.
- Back-to-back valid: hold instr_valid high for two instructions -> second accepted exactly 5 cycles after first. instr_ready=0 during cycles T+1 through T+4.
- Reset mid-op: assert rst in OPLD -> next cycle IDLE, no rf_write, instr_cnt=0, all outputs at reset values.
- Self-overwrite and wrap: rs1=rd=5 with R5=0xFFFF0000, R6=0x0000FFFF -> R5=0xFFFFFFFF. Preload instr_cnt to 0xFFFF via 65535 retires, or run with CNT_WIDTH=2 and 4 retires -> instr_cnt=0.
